// File: rtl/mem_update_sched_if.sv
// Bundle of the requester, downstream-processor and memory-write signals
// around mem_update_sched. The scheduler connects through the master modport
// and the surrounding logic through the slave modport.
interface mem_update_sched_if #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] addr_in;
   logic [NREQ*DW-1:0] data_in;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic               err;
   logic               dp_ack;
   logic               dp_busy;
   logic               mem_wr;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;

   modport master (
      input  req, addr_in, data_in, dp_busy,
      output grant, done, err, dp_ack, mem_wr, mem_addr, mem_wdata
   );

   modport slave (
      output req, addr_in, data_in, dp_busy,
      input  grant, done, err, dp_ack, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_update_sched.sv
// Round-robin scheduler sharing one downstream memory-update processor
// between NREQ requesters. One transaction at a time: arbitrate, pulse ack,
// wait for busy, hold the write strobe until busy drops, then pulse done.
// A watchdog aborts with err if the processor stalls in WAIT_BUSY or WRITE.
module mem_update_sched #(
   parameter int NREQ    = 4,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            HRESETn,
   mem_update_sched_if.master bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      WAIT_BUSY,
      WRITE,
      DONE
   } state_t;

   state_t            state;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     idx;
   logic [WW-1:0]     wd;
   logic [NREQ-1:0]   grant_q;
   logic [NREQ-1:0]   done_q;
   logic              err_q;
   logic              dp_ack_q;
   logic              mem_wr_q;
   logic [AW-1:0]     mem_addr_q;
   logic [DW-1:0]     mem_wdata_q;

   logic              found;
   logic [PW-1:0]     win;
   logic [PW-1:0]     cand;
   int unsigned       j;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // First requesting index at or after ptr, wrapping at NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      j     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = 32'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         cand = PW'(j);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Transaction FSM; every output is a register updated on the state transition.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         ptr         <= '0;
         idx         <= '0;
         wd          <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         dp_ack_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         dp_ack_q <= 1'b0;
         done_q   <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  idx         <= win;
                  mem_addr_q  <= bus.addr_in[32'(win)*AW +: AW];
                  mem_wdata_q <= bus.data_in[32'(win)*DW +: DW];
                  grant_q     <= onehot(win);
                  dp_ack_q    <= 1'b1;
                  state       <= ACK;
               end
            end
            ACK: begin
               wd    <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // busy takes priority over an expiring watchdog
               if (bus.dp_busy) begin
                  wd       <= '0;
                  mem_wr_q <= 1'b1;
                  state    <= WRITE;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  err_q  <= 1'b1;
                  done_q <= onehot(idx);
                  state  <= DONE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            WRITE: begin
               if (!bus.dp_busy) begin
                  mem_wr_q <= 1'b0;
                  err_q    <= 1'b0;
                  done_q   <= onehot(idx);
                  state    <= DONE;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  mem_wr_q <= 1'b0;
                  err_q    <= 1'b1;
                  done_q   <= onehot(idx);
                  state    <= DONE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            DONE: begin
               grant_q <= '0;
               err_q   <= 1'b0;
               ptr     <= (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.dp_ack    = dp_ack_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_update_sched.sv
// Scoreboard bench for mem_update_sched: a driver raises requests and predicts
// each transaction (winner, latched addr/data, phase lengths, err) from the
// round-robin rule; a downstream-processor model responds with per-transaction
// busy timing; a monitor pops predictions as done pulses appear.
module tb_mem_update_sched;
   localparam int NREQ    = 4;
   localparam int AW      = 8;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;

   logic clk     = 1'b0;
   logic HRESETn = 1'b0;
   always #5 clk = ~clk;

   mem_update_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   mem_update_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   typedef struct {
      int            idx;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
      int            wb;
      int            wr;
   } exp_t;

   typedef struct {
      int d;   // busy rises at the end of WAIT_BUSY cycle d; 0 = never
      int w;   // busy falls w cycles after the first mem_wr cycle
   } ds_t;

   exp_t exp_q[$];
   ds_t  ds_q[$];
   int   errors = 0;
   int   checks = 0;
   int   mptr   = 0;
   int   cur_win = 0;

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic summary_and_finish();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic add_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.addr_in[i*AW +: AW] = a;
      bus.data_in[i*DW +: DW] = d;
      bus.req[i]              = 1'b1;
   endtask

   task automatic add_rand(input int i);
      add_req(i, AW'($urandom), DW'($urandom));
   endtask

   // Predict the next transaction from the current request set.
   task automatic launch(input int d, input int w);
      exp_t e;
      ds_t  p;
      int   win;
      win = -1;
      for (int k = 0; k < NREQ; k++)
         if (win < 0 && bus.req[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
      if (win < 0) return;
      e.idx  = win;
      e.addr = bus.addr_in[win*AW +: AW];
      e.data = bus.data_in[win*DW +: DW];
      if (d == 0) begin
         e.wb = TIMEOUT; e.wr = 0; e.err = 1'b1;
      end else begin
         e.wb = d;
         if (w >= TIMEOUT) begin
            e.wr = TIMEOUT; e.err = 1'b1;
         end else begin
            e.wr = w + 1; e.err = 1'b0;
         end
      end
      p.d = d;
      p.w = w;
      exp_q.push_back(e);
      ds_q.push_back(p);
      cur_win = win;
      mptr    = (win + 1) % NREQ;
   endtask

   task automatic finish_txn();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done == '0 && n < 200);
      if (bus.done == '0) begin
         errors++;
         checks++;
         $display("FAIL done_wait: no done within 200 cycles at %0t", $time);
         summary_and_finish();
      end
      bus.req[cur_win] = 1'b0;
   endtask

   task automatic pick_dw(output int d, output int w);
      int r;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 0 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 4));
      r = int'($urandom_range(0, 9));
      w = (r == 0) ? 16 : (r == 1) ? 14 : (r == 2) ? 15 : int'($urandom_range(1, 4));
   endtask

   // Downstream processor model.
   initial begin
      ds_t p;
      bit  stop;
      bus.dp_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (HRESETn && bus.dp_ack && ds_q.size() > 0) begin
            p    = ds_q.pop_front();
            stop = 1'b0;
            if (p.d != 0) begin
               for (int k = 0; k < p.d && !stop; k++) begin
                  @(negedge clk);
                  if (!HRESETn) stop = 1'b1;
               end
               if (!stop) begin
                  bus.dp_busy = 1'b1;
                  @(negedge clk);
                  if (!HRESETn) stop = 1'b1;
               end
               for (int k = 0; k < p.w && !stop; k++) begin
                  @(negedge clk);
                  if (!HRESETn || bus.done != '0) stop = 1'b1;
               end
               bus.dp_busy = 1'b0;
            end
         end
      end
   end

   // Monitor / scoreboard.
   int   gcnt, ackc, wbc, wrc;
   exp_t me;
   initial begin
      gcnt = 0; ackc = 0; wbc = 0; wrc = 0;
      forever begin
         @(negedge clk);
         if (!HRESETn) begin
            gcnt = 0; ackc = 0; wbc = 0; wrc = 0;
         end else begin
            if (bus.grant != '0) gcnt++;
            if (bus.dp_ack) ackc++;
            if (bus.mem_wr) begin
               wrc++;
               if (exp_q.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL mem_wr_unexpected: mem_wr=1 with no transaction expected at %0t", $time);
               end else begin
                  me = exp_q[0];
                  check("mem_addr", bus.mem_addr, me.addr);
                  check("mem_wdata", bus.mem_wdata, me.data);
                  check("grant_in_write", bus.grant, oh(me.idx));
               end
            end else if (bus.grant != '0 && !bus.dp_ack && bus.done == '0) begin
               wbc++;
            end
            if (bus.done != '0) begin
               if (exp_q.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL done_unexpected: done=0x%0h with no transaction expected at %0t", bus.done, $time);
               end else begin
                  me = exp_q.pop_front();
                  check("done", bus.done, oh(me.idx));
                  check("err", bus.err, me.err);
                  check("grant_at_done", bus.grant, oh(me.idx));
                  check("ack_cycles", ackc, 1);
                  check("wait_busy_cycles", wbc, me.wb);
                  check("write_cycles", wrc, me.wr);
                  check("grant_cycles", gcnt, me.wb + me.wr + 2);
               end
               gcnt = 0; ackc = 0; wbc = 0; wrc = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL global_timeout: simulation time limit reached");
      summary_and_finish();
   end

   // Driver.
   initial begin
      int d, w, n;
      bus.req     = '0;
      bus.addr_in = '0;
      bus.data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_grant", bus.grant, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_dp_ack", bus.dp_ack, 0);
      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      HRESETn = 1'b1;
      @(negedge clk);

      // single nominal transaction on requester 0
      add_req(0, 8'h3C, 32'hDEADBEEF);
      launch(1, 1); finish_txn();
      // move the pointer back to 0 so the all-request round starts at 0
      add_rand(3); launch(1, 1); finish_txn();
      // fairness: all four, each drops on its own done
      for (int i = 0; i < NREQ; i++) add_rand(i);
      for (int i = 0; i < NREQ; i++) begin launch(1, 1); finish_txn(); end
      // pointer wrap after requester 3
      add_rand(0); add_rand(3);
      launch(1, 1); finish_txn();
      launch(2, 2); finish_txn();
      // busy never rises
      add_rand(1); launch(0, 1); finish_txn();
      // busy never clears
      add_rand(2); launch(1, 16); finish_txn();
      // boundaries: busy on last watchdog cycle, busy drop on last write cycle, one beyond
      add_rand(0); launch(TIMEOUT, 1); finish_txn();
      add_rand(1); launch(1, TIMEOUT - 1); finish_txn();
      add_rand(2); launch(2, TIMEOUT); finish_txn();

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         if (bus.req == '0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            add_rand(int'($urandom_range(0, NREQ - 1)));
         end
         for (int i = 0; i < NREQ; i++)
            if (!bus.req[i] && $urandom_range(0, 2) == 0) add_rand(i);
         pick_dw(d, w);
         launch(d, w); finish_txn();
      end
      // drain whatever is still pending
      while (bus.req != '0) begin
         launch(1, 1); finish_txn();
      end

      // reset in the middle of WRITE; ptr is left at 3 beforehand
      add_rand(2); launch(1, 1); finish_txn();
      add_rand(1); launch(1, 16);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_wr && n < 50);
      if (!bus.mem_wr) begin
         errors++; checks++;
         $display("FAIL mem_wr_wait: mem_wr never asserted at %0t", $time);
         summary_and_finish();
      end
      HRESETn = 1'b0;
      #1;
      check("rst_mid_mem_wr", bus.mem_wr, 0);
      check("rst_mid_grant", bus.grant, 0);
      check("rst_mid_done", bus.done, 0);
      check("rst_mid_dp_ack", bus.dp_ack, 0);
      exp_q.delete();
      ds_q.delete();
      bus.req = '0;
      mptr    = 0;
      repeat (2) @(negedge clk);
      HRESETn = 1'b1;
      // with ptr cleared to 0, requester 2 must win over 3
      add_rand(2); add_rand(3);
      launch(1, 1); finish_txn();
      launch(1, 1); finish_txn();
      repeat (3) @(negedge clk);
      check("queue_empty_at_end", exp_q.size(), 0);
      summary_and_finish();
   end

endmodule
